ped_signal_ctrl: RTL and testbench

Pedestrian signal controller sitting directly downstream of the intersection light sequencer. It consumes the registered NS/EW vehicle light codes, latches pedestrian push-button requests, and drives WALK / DON'T WALK heads with a flashing clearance interval and countdown for each crossing. One independent channel serves pedestrians moving parallel to NS traffic and another serves those parallel to EW traffic; an optional safety checker forces both channels to DON'T WALK on illegal light codes.

---
 rtl/ped_signal_ctrl_if.sv | 31 +++
 rtl/ped_signal_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ped_signal_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ped_signal_ctrl_if.sv
// Signal bundle between the light sequencer / button inputs and the pedestrian heads.
// The master drives light codes and buttons; the slave (controller) drives lamps and status.
interface ped_signal_ctrl_if #(
    parameter int CW = 8
);
    logic [2:0]    NS_light;
    logic [2:0]    EW_light;
    logic          ped_btn_ns;
    logic          ped_btn_ew;
    logic          walk_ns;
    logic          walk_ew;
    logic          dont_walk_ns;
    logic          dont_walk_ew;
    logic [CW-1:0] countdown_ns;
    logic [CW-1:0] countdown_ew;
    logic          req_pending_ns;
    logic          req_pending_ew;
    logic          fault;

    modport master (
        output NS_light, EW_light, ped_btn_ns, ped_btn_ew,
        input  walk_ns, walk_ew, dont_walk_ns, dont_walk_ew,
        input  countdown_ns, countdown_ew, req_pending_ns, req_pending_ew, fault
    );

    modport slave (
        input  NS_light, EW_light, ped_btn_ns, ped_btn_ew,
        output walk_ns, walk_ew, dont_walk_ns, dont_walk_ew,
        output countdown_ns, countdown_ew, req_pending_ns, req_pending_ew, fault
    );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / flashing DON'T WALK controller, channel 0 = NS-parallel, channel 1 = EW-parallel.
// Define PED_FAULT_CHECK_EN to add the sticky illegal-light-code checker that blocks all grants.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 100,
    parameter int CLEAR_CYCLES = 60,
    parameter int FLASH_HALF   = 5,
    parameter int CW           = 8
) (
    input  logic             clk,
    input  logic             reset,
    ped_signal_ctrl_if.slave bus
);
    localparam int NCH = 2;
    localparam int WCW = (WALK_CYCLES > 1) ? $clog2(WALK_CYCLES) : 1;
    localparam int FCW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [WCW-1:0] WALK_LOAD  = WCW'(WALK_CYCLES - 1);
    localparam logic [FCW-1:0] FLASH_LOAD = FCW'(FLASH_HALF - 1);
    localparam logic [CW-1:0]  CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    logic [2:0]     light [NCH];
    logic [NCH-1:0] btn;
    logic [NCH-1:0] green;
    logic [NCH-1:0] red;
    logic [NCH-1:0] green_rise;
    logic           force_idle;
    logic           unused_bits;

    state_t         state_q     [NCH];
    state_t         state_d     [NCH];
    logic [2:0]     light_q     [NCH];
    logic [2:0]     light_d     [NCH];
    logic [CW-1:0]  countdown_q [NCH];
    logic [CW-1:0]  countdown_d [NCH];
    logic [WCW-1:0] walk_cnt_q  [NCH];
    logic [WCW-1:0] walk_cnt_d  [NCH];
    logic [FCW-1:0] flash_cnt_q [NCH];
    logic [FCW-1:0] flash_cnt_d [NCH];
    logic [NCH-1:0] req_q, req_d;
    logic [NCH-1:0] walk_q, walk_d;
    logic [NCH-1:0] dont_walk_q, dont_walk_d;

    always_comb begin
        light[0]   = bus.NS_light;
        light[1]   = bus.EW_light;
        btn        = {bus.ped_btn_ew, bus.ped_btn_ns};
        green      = '0;
        red        = '0;
        green_rise = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            green[c]      = light[c][0];
            red[c]        = light[c][2];
            green_rise[c] = light[c][0] & ~light_q[c][0];
        end
    end

`ifdef PED_FAULT_CHECK_EN
    logic fault_q, fault_d;
    logic viol;

    // A violation blocks grants on the very edge it is registered, not one cycle later.
    always_comb begin
        viol = !$onehot(light[0]) || !$onehot(light[1]) || (light[0][0] && light[1][0]);
        fault_d     = fault_q | viol;
        force_idle  = fault_d;
        bus.fault   = fault_q;
        unused_bits = ^{light_q[0][2:1], light_q[1][2:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    always_comb begin
        force_idle  = 1'b0;
        bus.fault   = 1'b0;
        unused_bits = ^{light_q[0][2:1], light_q[1][2:1], light[0][1], light[1][1]};
    end
`endif

    always_comb begin
        req_d       = req_q | btn;
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        for (int unsigned c = 0; c < NCH; c++) begin
            state_d[c]     = state_q[c];
            light_d[c]     = light[c];
            countdown_d[c] = countdown_q[c];
            walk_cnt_d[c]  = walk_cnt_q[c];
            flash_cnt_d[c] = flash_cnt_q[c];
            case (state_q[c])
                S_IDLE: begin
                    if (!force_idle && green_rise[c] && (req_q[c] || btn[c])) begin
                        state_d[c]     = S_WALK;
                        walk_d[c]      = 1'b1;
                        dont_walk_d[c] = 1'b0;
                        walk_cnt_d[c]  = WALK_LOAD;
                        req_d[c]       = 1'b0;
                    end
                end
                S_WALK: begin
                    if (force_idle || red[c]) begin
                        state_d[c]     = S_IDLE;
                        walk_d[c]      = 1'b0;
                        dont_walk_d[c] = 1'b1;
                    end else if (!green[c] || walk_cnt_q[c] == '0) begin
                        state_d[c]     = S_CLEAR;
                        walk_d[c]      = 1'b0;
                        dont_walk_d[c] = 1'b1;
                        countdown_d[c] = CLEAR_LOAD;
                        flash_cnt_d[c] = FLASH_LOAD;
                    end else begin
                        walk_cnt_d[c] = walk_cnt_q[c] - 1'b1;
                    end
                end
                S_CLEAR: begin
                    // Zero is displayed for one full cycle before returning to solid DON'T WALK.
                    if (force_idle || red[c] || countdown_q[c] == '0) begin
                        state_d[c]     = S_IDLE;
                        dont_walk_d[c] = 1'b1;
                        countdown_d[c] = '0;
                    end else begin
                        countdown_d[c] = countdown_q[c] - 1'b1;
                        if (flash_cnt_q[c] == '0) begin
                            dont_walk_d[c] = ~dont_walk_q[c];
                            flash_cnt_d[c] = FLASH_LOAD;
                        end else begin
                            flash_cnt_d[c] = flash_cnt_q[c] - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[c]     = S_IDLE;
                    walk_d[c]      = 1'b0;
                    dont_walk_d[c] = 1'b1;
                    countdown_d[c] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q       <= '0;
            walk_q      <= '0;
            dont_walk_q <= '1;
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c]     <= S_IDLE;
                light_q[c]     <= 3'b100;
                countdown_q[c] <= '0;
                walk_cnt_q[c]  <= '0;
                flash_cnt_q[c] <= '0;
            end
        end else begin
            req_q       <= req_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c]     <= state_d[c];
                light_q[c]     <= light_d[c];
                countdown_q[c] <= countdown_d[c];
                walk_cnt_q[c]  <= walk_cnt_d[c];
                flash_cnt_q[c] <= flash_cnt_d[c];
            end
        end
    end

    always_comb begin
        bus.walk_ns        = walk_q[0];
        bus.walk_ew        = walk_q[1];
        bus.dont_walk_ns   = dont_walk_q[0];
        bus.dont_walk_ew   = dont_walk_q[1];
        bus.countdown_ns   = countdown_q[0];
        bus.countdown_ew   = countdown_q[1];
        bus.req_pending_ns = req_q[0];
        bus.req_pending_ew = req_q[1];
    end
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed plus randomized bench for ped_signal_ctrl; expectations come from a phase/age model.
// Honours PED_FAULT_CHECK_EN the same way the design does.
module tb_ped_signal_ctrl;
    localparam int WC = 4;
    localparam int CC = 3;
    localparam int FH = 1;
    localparam int CW = 8;

    typedef enum int {M_IDLE, M_WALK, M_CLEAR} mph_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mph_t m_ph  [2];
    int   m_age [2];
    bit   m_rq  [2];
    bit   m_pg  [2];
    bit   m_fault;

    ped_signal_ctrl_if #(.CW(CW)) bus ();

    ped_signal_ctrl #(
        .WALK_CYCLES (WC),
        .CLEAR_CYCLES(CC),
        .FLASH_HALF  (FH),
        .CW          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_ph[c]  = M_IDLE;
            m_age[c] = 0;
            m_rq[c]  = 1'b0;
            m_pg[c]  = 1'b0;
        end
        m_fault = 1'b0;
    endtask

    // One clock edge of the behavioural rules: phase plus cycles spent in that phase.
    task automatic model_update();
        logic [2:0] l [2];
        bit b [2];
        bit g, r, rise;
        l[0] = bus.NS_light;
        l[1] = bus.EW_light;
        b[0] = bus.ped_btn_ns;
        b[1] = bus.ped_btn_ew;
        if (!reset) begin
            model_reset();
            return;
        end
`ifdef PED_FAULT_CHECK_EN
        if ($countones(l[0]) != 1 || $countones(l[1]) != 1 || (l[0][0] && l[1][0]))
            m_fault = 1'b1;
`endif
        for (int c = 0; c < 2; c++) begin
            g    = l[c][0];
            r    = l[c][2];
            rise = g && !m_pg[c];
            if (m_ph[c] == M_IDLE && !m_fault && rise && (m_rq[c] || b[c])) begin
                m_ph[c]  = M_WALK;
                m_age[c] = 0;
                m_rq[c]  = 1'b0;
            end else begin
                m_rq[c] = m_rq[c] || b[c];
                if (m_ph[c] == M_WALK) begin
                    if (m_fault || r) begin
                        m_ph[c] = M_IDLE;
                    end else if (!g || m_age[c] + 1 == WC) begin
                        m_ph[c]  = M_CLEAR;
                        m_age[c] = 0;
                    end else begin
                        m_age[c]++;
                    end
                end else if (m_ph[c] == M_CLEAR) begin
                    if (m_fault || r || m_age[c] + 1 == CC) m_ph[c] = M_IDLE;
                    else m_age[c]++;
                end
            end
            m_pg[c] = g;
        end
    endtask

    task automatic check_all();
        logic          e_w  [2];
        logic          e_dw [2];
        logic [CW-1:0] e_cd [2];
        for (int c = 0; c < 2; c++) begin
            e_w[c]  = (m_ph[c] == M_WALK);
            e_dw[c] = (m_ph[c] == M_IDLE) || (m_ph[c] == M_CLEAR && ((m_age[c] / FH) % 2 == 0));
            e_cd[c] = (m_ph[c] == M_CLEAR) ? CW'(CC - 1 - m_age[c]) : '0;
        end
        chk1("walk_ns", bus.walk_ns, e_w[0]);
        chk1("walk_ew", bus.walk_ew, e_w[1]);
        chk1("dont_walk_ns", bus.dont_walk_ns, e_dw[0]);
        chk1("dont_walk_ew", bus.dont_walk_ew, e_dw[1]);
        chkc("countdown_ns", bus.countdown_ns, e_cd[0]);
        chkc("countdown_ew", bus.countdown_ew, e_cd[1]);
        chk1("req_pending_ns", bus.req_pending_ns, m_rq[0]);
        chk1("req_pending_ew", bus.req_pending_ew, m_rq[1]);
        chk1("fault", bus.fault, m_fault);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        check_all();
    endtask

    initial begin
        logic [CW-1:0] exp_cd [3];
        logic          exp_dw [3];
        logic          fault_on;
        int            rs [2];
        int            rr [2];
        exp_cd = '{8'd2, 8'd1, 8'd0};
        exp_dw = '{1'b1, 1'b0, 1'b1};
`ifdef PED_FAULT_CHECK_EN
        fault_on = 1'b1;
`else
        fault_on = 1'b0;
`endif
        reset          = 1'b0;
        bus.NS_light   = 3'b100;
        bus.EW_light   = 3'b100;
        bus.ped_btn_ns = 1'b0;
        bus.ped_btn_ew = 1'b0;
        model_reset();

        // Reset hold
        repeat (10) step();
        chk1("rst_dont_walk_ns", bus.dont_walk_ns, 1'b1);
        chk1("rst_walk_ew", bus.walk_ew, 1'b0);
        chkc("rst_countdown_ns", bus.countdown_ns, 8'd0);
        chk1("rst_fault", bus.fault, 1'b0);
        #2 reset = 1'b1;
        step();

        // Normal grant
        bus.ped_btn_ns = 1'b1;
        step();
        chk1("req_ns_set", bus.req_pending_ns, 1'b1);
        bus.ped_btn_ns = 1'b0;
        bus.NS_light   = 3'b001;
        for (int i = 0; i < WC; i++) begin
            step();
            chk1("grant_walk_ns", bus.walk_ns, 1'b1);
            if (i == 0) chk1("grant_req_clr", bus.req_pending_ns, 1'b0);
        end
        for (int i = 0; i < CC; i++) begin
            step();
            chk1("clear_walk_ns", bus.walk_ns, 1'b0);
            chkc("clear_countdown_ns", bus.countdown_ns, exp_cd[i]);
            chk1("clear_flash_ns", bus.dont_walk_ns, exp_dw[i]);
        end
        step();
        chk1("end_dont_walk_ns", bus.dont_walk_ns, 1'b1);
        chkc("end_countdown_ns", bus.countdown_ns, 8'd0);

        // Green without request
        bus.NS_light = 3'b100;
        repeat (2) step();
        bus.NS_light = 3'b001;
        repeat (20) begin
            step();
            chk1("noreq_walk_ns", bus.walk_ns, 1'b0);
            chk1("noreq_dont_walk_ns", bus.dont_walk_ns, 1'b1);
        end

        // Late press mid-green, then early yellow and red during clearance
        bus.ped_btn_ns = 1'b1;
        step();
        bus.ped_btn_ns = 1'b0;
        step();
        chk1("late_no_walk", bus.walk_ns, 1'b0);
        chk1("late_req_held", bus.req_pending_ns, 1'b1);
        bus.NS_light = 3'b010;
        step();
        bus.NS_light = 3'b100;
        repeat (2) step();
        bus.NS_light = 3'b001;
        step();
        chk1("late_walk_next_green", bus.walk_ns, 1'b1);
        step();
        bus.NS_light = 3'b010;
        step();
        chk1("drop_walk_off", bus.walk_ns, 1'b0);
        chkc("drop_countdown", bus.countdown_ns, 8'd2);
        chk1("drop_dont_walk", bus.dont_walk_ns, 1'b1);
        bus.NS_light = 3'b100;
        step();
        chkc("red_forced_cd", bus.countdown_ns, 8'd0);
        chk1("red_forced_dw", bus.dont_walk_ns, 1'b1);

        // Concurrent channels
        bus.ped_btn_ns = 1'b1;
        bus.ped_btn_ew = 1'b1;
        step();
        chk1("conc_req_ew", bus.req_pending_ew, 1'b1);
        bus.ped_btn_ns = 1'b0;
        bus.ped_btn_ew = 1'b0;
        bus.NS_light   = 3'b001;
        step();
        chk1("conc_walk_ns", bus.walk_ns, 1'b1);
        chk1("conc_ew_idle", bus.walk_ew, 1'b0);
        bus.NS_light = 3'b010;
        bus.EW_light = 3'b001;
        step();
        chkc("conc_cd_ns", bus.countdown_ns, 8'd2);
        chk1("conc_walk_ew", bus.walk_ew, 1'b1);
        repeat (3) step();
        chk1("conc_ew_still_walk", bus.walk_ew, 1'b1);
        step();
        chkc("conc_cd_ew", bus.countdown_ew, 8'd2);
        chk1("conc_ns_idle", bus.dont_walk_ns, 1'b1);
        bus.NS_light = 3'b100;
        bus.EW_light = 3'b100;
        repeat (3) step();

        // Asynchronous reset mid-WALK drops pending requests
        bus.ped_btn_ns = 1'b1;
        bus.ped_btn_ew = 1'b1;
        step();
        bus.ped_btn_ns = 1'b0;
        bus.ped_btn_ew = 1'b0;
        bus.NS_light   = 3'b001;
        step();
        step();
        reset = 1'b0;
        #1;
        model_reset();
        chk1("areset_walk_ns", bus.walk_ns, 1'b0);
        chk1("areset_dont_walk_ns", bus.dont_walk_ns, 1'b1);
        chk1("areset_req_ew", bus.req_pending_ew, 1'b0);
        bus.NS_light = 3'b100;
        repeat (2) step();
        reset = 1'b1;
        step();

        // Randomized legal light sequences and buttons
        rs = '{2, 2};
        rr = '{1, 3};
        for (int n = 0; n < 500; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (rr[c] == 0) begin
                    if (rs[c] == 0) rs[c] = ($urandom_range(0, 3) == 0) ? 2 : 1;
                    else if (rs[c] == 1) rs[c] = 2;
                    else rs[c] = 0;
                    rr[c] = (rs[c] == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 4));
                end
                rr[c]--;
            end
            if (rs[0] == 0 && rs[1] == 0) begin
                rs[1] = 2;
                rr[1] = 2;
            end
            bus.NS_light   = (rs[0] == 0) ? 3'b001 : (rs[0] == 1) ? 3'b010 : 3'b100;
            bus.EW_light   = (rs[1] == 0) ? 3'b001 : (rs[1] == 1) ? 3'b010 : 3'b100;
            bus.ped_btn_ns = ($urandom_range(0, 5) == 0);
            bus.ped_btn_ew = ($urandom_range(0, 5) == 0);
            step();
        end

        // Fault: both greens together, then a legal request/green
        bus.NS_light   = 3'b100;
        bus.EW_light   = 3'b100;
        bus.ped_btn_ns = 1'b0;
        bus.ped_btn_ew = 1'b0;
        reset          = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        bus.NS_light = 3'b001;
        bus.EW_light = 3'b001;
        step();
        chk1("fault_set", bus.fault, fault_on);
        chk1("fault_walk_ns", bus.walk_ns, 1'b0);
        chk1("fault_walk_ew", bus.walk_ew, 1'b0);
        bus.NS_light = 3'b100;
        bus.EW_light = 3'b100;
        step();
        bus.ped_btn_ns = 1'b1;
        step();
        bus.ped_btn_ns = 1'b0;
        bus.NS_light   = 3'b001;
        step();
        chk1("fault_blocks_grant", bus.walk_ns, !fault_on);
        chk1("fault_sticky", bus.fault, fault_on);
        repeat (3) step();
        bus.NS_light = 3'b100;
        reset        = 1'b0;
        step();
        chk1("fault_cleared_by_reset", bus.fault, 1'b0);
        reset = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
